// File: rtl/alu_mc.sv
// Multi-cycle RV32IM ALU: base ops in one cycle, M ops via a radix-2 shift-add / restoring-divide datapath.
// Valid/ready on both sides; flush aborts in-flight work, results are held in DONE until out_ready.
module alu_mc #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, FIX, DONE} state_t;

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_AND    = 5'h02;
    localparam logic [4:0] OP_OR     = 5'h03;
    localparam logic [4:0] OP_XOR    = 5'h04;
    localparam logic [4:0] OP_SLL    = 5'h05;
    localparam logic [4:0] OP_SRL    = 5'h06;
    localparam logic [4:0] OP_SRA    = 5'h07;
    localparam logic [4:0] OP_SLT    = 5'h08;
    localparam logic [4:0] OP_SLTU   = 5'h09;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;

    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

    state_t state, nxt;

    // Working registers: hi/lo hold the 2*XLEN product, or remainder/quotient when dividing.
    logic [XLEN-1:0]  hi, lo, opnd;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       mop;
    logic             neg_q, neg_r;

    // Accept-side decode
    logic             is_base, is_m, is_div, div_sgn, a_sgn, b_sgn;
    logic             a_neg, b_neg, div_zero, div_ovf, fast;
    logic [XLEN-1:0]  a_mag, b_mag, idle_res;
    logic [CNT_W-1:0] shamt;
    logic             accept;

    always_comb begin
        is_base  = (op <= OP_SLTU);
        is_m     = (op[4:3] == 2'b10);
        is_div   = is_m && op[2];
        div_sgn  = is_div && !op[0];
        a_sgn    = (op == OP_MULH) || (op == OP_MULHSU) || div_sgn;
        b_sgn    = (op == OP_MULH) || div_sgn;
        a_neg    = a_sgn && a[XLEN-1];
        b_neg    = b_sgn && b[XLEN-1];
        a_mag    = a_neg ? (~a + 1'b1) : a;
        b_mag    = b_neg ? (~b + 1'b1) : b;
        div_zero = is_div && (b == '0);
        div_ovf  = div_sgn && (a == MIN_NEG) && (b == '1);
        fast     = !is_m || div_zero || div_ovf;
        shamt    = b[CNT_W-1:0];
        idle_res = '0;
        case (op)
            OP_ADD:  idle_res = a + b;
            OP_SUB:  idle_res = a - b;
            OP_AND:  idle_res = a & b;
            OP_OR:   idle_res = a | b;
            OP_XOR:  idle_res = a ^ b;
            OP_SLL:  idle_res = a << shamt;
            OP_SRL:  idle_res = a >> shamt;
            OP_SRA:  idle_res = $signed(a) >>> shamt;
            OP_SLT:  idle_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: idle_res = {{(XLEN-1){1'b0}}, (a < b)};
            default: idle_res = '0;
        endcase
        // Degenerate divides short-circuit: op[1] selects remainder
        if (is_div) begin
            if (op[1]) idle_res = div_zero ? a : '0;
            else       idle_res = div_zero ? '1 : a;
        end
    end

    assign accept = (state == IDLE) && in_valid && !flush;

    // One radix-2 iteration of each datapath
    logic [XLEN:0] mul_sum, div_shift, div_diff;
    logic          div_ok;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ok    = !div_diff[XLEN];
    end

    // Sign fix-up
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

    always_comb begin
        prod     = {hi, lo};
        prod_fix = neg_q ? (~prod + 1'b1) : prod;
        quot_fix = neg_q ? (~lo + 1'b1) : lo;
        rem_fix  = neg_r ? (~hi + 1'b1) : hi;
        case (mop)
            3'd0:                fix_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fix_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fix_res = quot_fix;
            default:             fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (flush) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) nxt = fast ? DONE : EXEC;
                EXEC:    if (cnt == LAST) nxt = FIX;
                FIX:     nxt = DONE;
                DONE:    if (out_ready) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi      <= '0;
            lo      <= '0;
            opnd    <= '0;
            cnt     <= '0;
            mop     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (accept) begin
            hi    <= '0;
            lo    <= is_div ? a_mag : b_mag;
            opnd  <= is_div ? b_mag : a_mag;
            cnt   <= '0;
            mop   <= op[2:0];
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (fast) begin
                result  <= idle_res;
                zero    <= (idle_res == '0);
                illegal <= !is_base && !is_m;
            end
        end else if (state == EXEC && !flush) begin
            cnt <= cnt + 1'b1;
            if (mop[2]) begin
                hi <= div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                lo <= {lo[XLEN-2:0], div_ok};
            end else begin
                hi <= mul_sum[XLEN:1];
                lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
        end else if (state == FIX && !flush) begin
            result  <= fix_res;
            zero    <= (fix_res == '0);
            illegal <= 1'b0;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule
